// File: rtl/ram_bist_pkg.sv
// Shared types and helpers for the RAM BIST sequencer: FSM state encoding and the
// address-derived test pattern (optionally inverted for the second sweep).
package ram_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_e;

  localparam int unsigned PAT_W = 32;

  // Pattern word for an address; callers truncate to the RAM word width.
  function automatic logic [PAT_W-1:0] pat(input logic [PAT_W-1:0] addr, input logic inv);
    logic [PAT_W-1:0] p;
    p = addr + PAT_W'(1);
    return inv ? ~p : p;
  endfunction

endpackage

// File: rtl/ram_bist_cmp.sv
// Read-data checker for the RAM BIST: RD_LAT-deep {valid, addr, expected} pipe aligned
// with the RAM read latency, word comparator and first-mismatch capture.
module ram_bist_cmp
  import ram_bist_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] exp_i,
  input  logic [DATA_WIDTH-1:0] q_i,
  output logic                  pass_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [DATA_WIDTH-1:0] fail_exp_o,
  output logic [DATA_WIDTH-1:0] fail_got_o,
  output logic                  front_empty_c
);

  logic [RD_LAT-1:0]     vld_q;
  logic [ADDR_WIDTH-1:0] addr_q [RD_LAT];
  logic [DATA_WIDTH-1:0] exp_q  [RD_LAT];
  logic                  pass_q;
  logic [ADDR_WIDTH-1:0] fail_addr_q;
  logic [DATA_WIDTH-1:0] fail_exp_q;
  logic [DATA_WIDTH-1:0] fail_got_q;

  // Pipe shift plus compare of the oldest entry against the RAM output this cycle.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      vld_q       <= '0;
      pass_q      <= 1'b1;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_got_q  <= '0;
    end else begin
      vld_q[0]  <= push_i;
      addr_q[0] <= addr_i;
      exp_q[0]  <= exp_i;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
        exp_q[i]  <= exp_q[i-1];
      end
      if (vld_q[RD_LAT-1] && pass_q && (q_i != exp_q[RD_LAT-1])) begin
        pass_q      <= 1'b0;
        fail_addr_q <= addr_q[RD_LAT-1];
        fail_exp_q  <= exp_q[RD_LAT-1];
        fail_got_q  <= q_i;
      end
    end
  end

  // True when nothing but the entry being compared right now is still in flight.
  if (RD_LAT > 1) begin : g_multi
    assign front_empty_c = ~|vld_q[RD_LAT-2:0];
  end else begin : g_single
    assign front_empty_c = 1'b1;
  end

  assign pass_o      = pass_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_exp_o  = fail_exp_q;
  assign fail_got_o  = fail_got_q;

endmodule

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: write-then-readback self-test sequencer for a single-port RAM.
// Define RAM_BIST_INV_PASS_EN to append a second sweep using the inverted pattern.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_got,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  we_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  inv_q;

  logic                  accept_c;
  logic                  push_c;
  logic                  front_empty_c;
  logic [DATA_WIDTH-1:0] exp_c;

  assign accept_c = (state_q == IDLE) && start;
  assign push_c   = (state_q == READ);
  assign exp_c    = DATA_WIDTH'(pat(PAT_W'(addr_q), inv_q));

  // Sequencer: address sweep for write and read phases, done/busy handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= WRITE;
            addr_q  <= '0;
            data_q  <= DATA_WIDTH'(pat(PAT_W'(0), 1'b0));
            we_q    <= 1'b1;
            busy_q  <= 1'b1;
            inv_q   <= 1'b0;
          end
        end
        WRITE: begin
          if (addr_q == ADDR_LAST) begin
            state_q <= READ;
            addr_q  <= '0;
            we_q    <= 1'b0;
          end else begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
            data_q <= DATA_WIDTH'(pat(PAT_W'(addr_q) + PAT_W'(1), inv_q));
          end
        end
        READ: begin
          if (addr_q == ADDR_LAST) begin
`ifdef RAM_BIST_INV_PASS_EN
            // Second sweep overlaps the tail of the first sweep's compare pipe.
            if (!inv_q) begin
              state_q <= WRITE;
              inv_q   <= 1'b1;
              addr_q  <= '0;
              data_q  <= DATA_WIDTH'(pat(PAT_W'(0), 1'b1));
              we_q    <= 1'b1;
            end else begin
              state_q <= DRAIN;
            end
`else
            state_q <= DRAIN;
`endif
          end else begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          if (front_empty_c) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  ram_bist_cmp #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .RD_LAT    (RD_LAT)
  ) u_cmp (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (accept_c),
    .push_i       (push_c),
    .addr_i       (addr_q),
    .exp_i        (exp_c),
    .q_i          (mem_q),
    .pass_o       (pass),
    .fail_addr_o  (fail_addr),
    .fail_exp_o   (fail_exp),
    .fail_got_o   (fail_got),
    .front_empty_c(front_empty_c)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign mem_data = data_q;
  assign mem_addr = addr_q;
  assign mem_we   = we_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: two instances (RD_LAT 1 and 2) each on a behavioural 8x64 RAM,
// checked every cycle against a timeline model derived from the edge count since start.
`timescale 1ns/1ps
module tb_ram_bist_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 64;
`ifdef RAM_BIST_INV_PASS_EN
  localparam int NS = 2;
`else
  localparam int NS = 1;
`endif
  localparam int SWEEP = 2 * DEPTH * NS;
  localparam int LAT0  = 1;
  localparam int LAT1  = 2;

  typedef struct packed {
    logic          p;
    logic [AW-1:0] fa;
    logic [DW-1:0] fe;
    logic [DW-1:0] fg;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  always #5 clk = ~clk;

  logic [1:0]         busy, done, pass, we;
  logic [1:0][AW-1:0] faddr, maddr;
  logic [1:0][DW-1:0] fexp, fgot, mdata, mq;

  ram_bist_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LAT(LAT0)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .fail_addr(faddr[0]), .fail_exp(fexp[0]), .fail_got(fgot[0]),
    .mem_data(mdata[0]), .mem_addr(maddr[0]), .mem_we(we[0]), .mem_q(mq[0])
  );

  ram_bist_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LAT(LAT1)) dut2 (
    .clk(clk), .rst(rst), .start(start), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .fail_addr(faddr[1]), .fail_exp(fexp[1]), .fail_got(fgot[1]),
    .mem_data(mdata[1]), .mem_addr(maddr[1]), .mem_we(we[1]), .mem_q(mq[1])
  );

  // Behavioural RAMs with registered address; the second has one extra output stage.
  logic [DW-1:0] mem [2][DEPTH];
  logic [AW-1:0] ra  [2];
  logic [DW-1:0] rd  [2];
  logic [DW-1:0] q2;
  bit fault_en;
  int fault_a, fault_b;
  bit fault_v;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      rd[k] = mem[k][ra[k]];
      if (fault_en && (ra[k] == AW'(fault_a))) rd[k][fault_b] = fault_v;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (we[k]) mem[k][maddr[k]] <= mdata[k];
      ra[k] <= maddr[k];
    end
    q2 <= rd[1];
  end

  assign mq[0] = rd[0];
  assign mq[1] = q2;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  bit   active = 1'b0;
  int   t = 0;
  res_t hold;

  function automatic logic [DW-1:0] bpat(input int a, input int s);
    logic [DW-1:0] v;
    v = DW'(a + 1);
    return (s != 0) ? ~v : v;
  endfunction

  // Outcome of a whole test from the fault setting: first sweep whose word is corrupted.
  function automatic res_t model_result();
    res_t r;
    logic [DW-1:0] e, g;
    r = {1'b1, {(AW + 2 * DW){1'b0}}};
    for (int s = 0; s < NS; s++) begin
      e = bpat(fault_a, s);
      g = e;
      g[fault_b] = fault_v;
      if (fault_en && (g != e) && r.p) begin
        r.p  = 1'b0;
        r.fa = AW'(fault_a);
        r.fe = e;
        r.fg = g;
      end
    end
    return r;
  endfunction

  // Model timeline: t counts edges since the accept edge.
  always @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      t      <= 0;
      hold   <= {1'b1, {(AW + 2 * DW){1'b0}}};
    end else if (!active) begin
      if (start) begin
        active <= 1'b1;
        t      <= 0;
        hold   <= model_result();
      end
    end else if (t >= SWEEP + LAT1 + 2) begin
      active <= 1'b0;
    end else begin
      t <= t + 1;
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0d got=%0h exp=%0h", nm, k, t, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        int tk, r, s;
        tk = SWEEP + ((k == 0) ? LAT0 : LAT1);
        r  = t % (2 * DEPTH);
        s  = t / (2 * DEPTH);
        if (active) begin
          chk("busy", k, 32'(busy[k]), 32'(t < tk));
          chk("done", k, 32'(done[k]), 32'(t == tk));
          if (t < SWEEP) begin
            chk("mem_we", k, 32'(we[k]), 32'(r < DEPTH));
            chk("mem_addr", k, 32'(maddr[k]), 32'(r % DEPTH));
            if (r < DEPTH) chk("mem_data", k, 32'(mdata[k]), 32'(bpat(r, s)));
          end else begin
            chk("mem_we_tail", k, 32'(we[k]), 32'(0));
          end
          if (t == 0) begin
            chk("pass_clr", k, 32'(pass[k]), 32'(1));
            chk("fail_addr_clr", k, 32'(faddr[k]), 32'(0));
          end
          if (t >= tk) begin
            chk("pass", k, 32'(pass[k]), 32'(hold.p));
            chk("fail_addr", k, 32'(faddr[k]), 32'(hold.fa));
            chk("fail_exp", k, 32'(fexp[k]), 32'(hold.fe));
            chk("fail_got", k, 32'(fgot[k]), 32'(hold.fg));
          end
        end else begin
          chk("idle_busy", k, 32'(busy[k]), 32'(0));
          chk("idle_done", k, 32'(done[k]), 32'(0));
          chk("idle_we", k, 32'(we[k]), 32'(0));
          chk("idle_pass", k, 32'(pass[k]), 32'(hold.p));
          chk("idle_fail_addr", k, 32'(faddr[k]), 32'(hold.fa));
          chk("idle_fail_exp", k, 32'(fexp[k]), 32'(hold.fe));
          chk("idle_fail_got", k, 32'(fgot[k]), 32'(hold.fg));
        end
      end
    end
  end

  // Called #1 after a rising edge; the following edge is the accept edge.
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_to_idle(input bit pulses, input int rst_t);
    int n = 0;
    while (active && n < 4 * SWEEP) begin
      start = pulses && (t > 0) && (t < SWEEP - 4) && ($urandom_range(0, 7) == 0);
      rst   = (t == rst_t);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    rst   = 1'b0;
    if (active) chk("idle_timeout", 0, 32'(1), 32'(0));
  endtask

  // Counts edges from accept to each done pulse and pins a few literal words on the way.
  task automatic directed_run();
    int n = 0;
`ifdef RAM_BIST_INV_PASS_EN
    localparam int DONE0 = 257;
`else
    localparam int DONE0 = 129;
`endif
    do_start();
    while (!done[0] && n < 1000) begin
      @(posedge clk); #1;
      n++;
      if (n == 5) begin
        chk("lit_w5_data", 0, 32'(mdata[0]), 32'h06);
        chk("lit_w5_we", 0, 32'(we[0]), 32'(1));
      end
      if (n == 64) begin
        chk("lit_r0_we", 0, 32'(we[0]), 32'(0));
        chk("lit_r0_addr", 0, 32'(maddr[0]), 32'(0));
      end
`ifdef RAM_BIST_INV_PASS_EN
      if (n == 128 + 5) begin
        chk("lit_inv_w5_addr", 0, 32'(maddr[0]), 32'(5));
        chk("lit_inv_w5_data", 0, 32'(mdata[0]), 32'hF9);
      end
`endif
    end
    chk("lit_done_edge", 0, 32'(n), 32'(DONE0));
    @(posedge clk); #1;
    n++;
    chk("lit_done_lat2", 1, 32'(done[1]), 32'(1));
    chk("lit_done_edge", 1, 32'(n), 32'(DONE0 + 1));
    run_to_idle(1'b0, -1);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    fault_en = 1'b0;
    fault_a  = 0;
    fault_b  = 0;
    fault_v  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    chk("lit_rst_pass", 0, 32'(pass[0]), 32'(1));
    chk("lit_rst_busy", 0, 32'(busy[0]), 32'(0));
    chk("lit_rst_we", 0, 32'(we[0]), 32'(0));
    chk("lit_rst_addr", 0, 32'(maddr[0]), 32'(0));
    repeat (2) @(posedge clk); #1;

    directed_run();
    chk("lit_clean_pass", 0, 32'(pass[0]), 32'(1));
    chk("lit_clean_pass", 1, 32'(pass[1]), 32'(1));

    fault_en = 1'b1; fault_a = 2; fault_b = 0; fault_v = 1'b0;
    directed_run();
    chk("lit_fault_pass", 0, 32'(pass[0]), 32'(0));
    chk("lit_fault_addr", 0, 32'(faddr[0]), 32'(2));
    chk("lit_fault_exp", 0, 32'(fexp[0]), 32'h03);
    chk("lit_fault_got", 0, 32'(fgot[0]), 32'h02);
    chk("lit_fault_got", 1, 32'(fgot[1]), 32'h02);

    fault_en = 1'b0;
    do_start();
    run_to_idle(1'b0, 10);
    chk("lit_rst_mid_we", 0, 32'(we[0]), 32'(0));
    chk("lit_rst_mid_busy", 0, 32'(busy[0]), 32'(0));
    chk("lit_rst_mid_pass", 0, 32'(pass[0]), 32'(1));
    @(posedge clk); #1;
    do_start();
    run_to_idle(1'b1, -1);
    chk("lit_after_rst_pass", 0, 32'(pass[0]), 32'(1));

    for (int i = 0; i < 6; i++) begin
      fault_en = bit'($urandom_range(0, 1));
      fault_a  = int'($urandom_range(0, DEPTH - 1));
      fault_b  = int'($urandom_range(0, DW - 1));
      fault_v  = bit'($urandom_range(0, 1));
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
      do_start();
      run_to_idle(1'b1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, SWEEP + 1)) : -1);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
